// File: rtl/ram_sync_param_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_param_if
// Description : Bus bundle for ram_sync_param: access requests, clear request,
//               read data, read strobe, busy flag and parity error.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              clear_req;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              err_inject;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              par_err;

    modport master (
        output clear_req, we, re, addr, data_in, err_inject,
        input  data_out, rd_valid, busy, par_err
    );

    modport slave (
        input  clear_req, we, re, addr, data_in, err_inject,
        output data_out, rd_valid, busy, par_err
    );
endinterface
`default_nettype wire

// File: rtl/ram_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_param
// Description : Single-port synchronous RAM with registered read, read-valid
//               strobe and a one-word-per-cycle hardware clear sweep.
//               Optional macro RAM_PARITY_EN adds a stored even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    ram_sync_param_if.slave bus
);

`ifdef RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [MEM_W-1:0]  r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [MEM_W-1:0]  w_mem_wdata;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;
    logic              w_rd_go;
    logic              w_in_range;

    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    // Only reachable when DEPTH is not a power of two.
    assign w_in_range = ({1'b0, bus.addr} < c_DEPTH);

`ifdef RAM_PARITY_EN
    assign w_wr_word = {(^bus.data_in) ^ bus.err_inject, bus.data_in};
`else
    assign w_wr_word = bus.data_in;
    logic w_unused_err_inject;
    assign w_unused_err_inject = bus.err_inject;
`endif

    assign w_rd_word = w_in_range ? r_mem[bus.addr] : '0;

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, memory write port and read launch
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_busy_nxt     = r_busy;
        w_mem_we       = 1'b0;
        w_mem_addr     = bus.addr;
        w_mem_wdata    = w_wr_word;
        w_rd_go        = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_addr;
                w_mem_wdata = '0;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_busy_nxt     = 1'b0;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + c_ADDR_ONE;
                end
            end
            default: begin
                // A clear request drops any access presented with it.
                if (bus.clear_req) begin
                    w_state_nxt    = ST_CLEAR;
                    w_busy_nxt     = 1'b1;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_mem_we = bus.we && w_in_range;
                    w_rd_go  = bus.re;
                end
            end
        endcase
    end

    // Array has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port (read-first against a same-cycle write)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_go) begin
            r_data_out <= w_rd_word[DATA_W-1:0];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

`ifdef RAM_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_rd_go) begin
            r_par_err <= (^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W];
        end else begin
            r_par_err <= 1'b0;
        end
    end

    assign bus.par_err = r_par_err;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sync_param
// Description : Directed, table-driven self-checking bench for ram_sync_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_param;

`ifdef RAM_PARITY_EN
    localparam logic c_EXP_PAR = 1'b1;
`else
    localparam logic c_EXP_PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    ram_sync_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

    ram_sync_param #(.DATA_W(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       we;
        logic       re;
        logic       inj;
        logic [3:0] addr;
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_par;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic we_i, input logic re_i, input logic clr_i,
                       input logic inj_i, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.we         = we_i;
        bus.re         = re_i;
        bus.clear_req  = clr_i;
        bus.err_inject = inj_i;
        bus.addr       = a;
        bus.data_in    = d;
        @(posedge clk);
        #1;
    endtask

    // Counts sampled cycles with busy high, starting from the current sample.
    task automatic sweep_len(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (bus.rd_valid !== 1'b0) saw_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        if (bus.rd_valid !== 1'b0) saw_valid = 1'b1;
    endtask

    initial begin
        int n;
        bit sv;

        bus.we = 1'b0; bus.re = 1'b0; bus.clear_req = 1'b0; bus.err_inject = 1'b0;
        bus.addr = '0; bus.data_in = '0;

        // Reset state and power-up sweep length
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_par", 32'(bus.par_err), 32'd0);
        rst = 1'b0;
        sweep_len(n, sv);
        check("sweep_len_reset", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'(a), 8'h00);
            check("zero_read_valid", 32'(bus.rd_valid), 32'd1);
            check("zero_read_data", 32'(bus.data_out), 32'd0);
        end

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd3,  8'hA5, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd15, 8'h3C, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd7,  8'h11, 1'b0, 8'h3C, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd7,  8'h22, 1'b1, 8'h11, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 8'h22, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'd4,  8'h01, 1'b0, 8'h22, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd5,  8'h03, 1'b0, 8'h22, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd4,  8'h00, 1'b1, 8'h01, c_EXP_PAR};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd5,  8'h00, 1'b1, 8'h03, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].we, vecs[i].re, 1'b0, vecs[i].inj, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_par", i), 32'(bus.par_err), 32'(vecs[i].exp_par));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
        end

        // Clear request wins over same-cycle write/read; held requests do not restart it
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'hFF);
        check("clr_busy", 32'(bus.busy), 32'd1);
        check("clr_valid", 32'(bus.rd_valid), 32'd0);
        bus.addr = 4'd9; bus.data_in = 8'h5A;
        sweep_len(n, sv);
        bus.clear_req = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        check("sweep_len_clear", 32'(n), 32'd16);
        check("clr_no_valid", 32'(sv), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        check("clr_addr2", 32'(bus.data_out), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
        check("clr_addr9", 32'(bus.data_out), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        check("clr_addr3", 32'(bus.data_out), 32'd0);
        check("clr_addr3_valid", 32'(bus.rd_valid), 32'd1);

        // Reset squashes a pending read and restarts a sweep in progress
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 8'h77);
        @(negedge clk);
        rst = 1'b1; bus.we = 1'b0; bus.re = 1'b1; bus.addr = 4'd1;
        @(posedge clk);
        #1;
        check("rst_rd_squash", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b0; bus.re = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_sweep_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep_len(n, sv);
        check("sweep_len_restart", 32'(n), 32'd16);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        check("restart_addr1", 32'(bus.data_out), 32'd0);
        check("restart_addr1_valid", 32'(bus.rd_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
